axis_rr_arbiter: RTL and testbench



---
 rtl/axis_rr_arbiter.sv | 73 +++++++
 tb/tb_axis_rr_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: round-robin share of one AXI4-Stream sink among N masters, each grant capped at BURST beats
module axis_rr_arbiter #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST      = 4
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [N-1:0]                   s_tvalid,
    output logic [N-1:0]                   s_tready,
    input  logic [N*DATA_WIDTH-1:0]        s_tdata,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic [DATA_WIDTH-1:0]          m_tdata,
    output logic [N-1:0]                   grant,
    output logic [$clog2(BURST+1)-1:0]     beat_cnt
);
    localparam int CW = $clog2(BURST + 1);
    localparam int PW = N > 1 ? $clog2(N) : 1;
    typedef enum logic {IDLE, GRANT} state_t;
    state_t         state, state_n;
    logic [N-1:0]   grant_n;
    logic [PW-1:0]  ptr, ptr_n;
    logic [CW-1:0]  cnt_n;
    logic           found, gv, hs;
    int             g, pick;
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state    <= IDLE;
            grant    <= '0;
            ptr      <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            ptr      <= ptr_n;
            beat_cnt <= cnt_n;
        end
    end
    always_comb begin
        g     = 0;
        found = 1'b0;
        pick  = 0;
        for (int i = 0; i < N; i++)
            if (grant[i]) g = i;
        for (int k = 0; k < N; k++)
            if (!found && s_tvalid[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                pick  = (int'(ptr) + k) % N;
            end
        gv       = state == GRANT;
        m_tvalid = gv & s_tvalid[g];
        m_tdata  = gv ? s_tdata[g*DATA_WIDTH +: DATA_WIDTH] : '0;
        s_tready = gv ? grant & {N{m_tready}} : '0;
        hs       = m_tvalid & m_tready;
        state_n  = state;
        grant_n  = grant;
        ptr_n    = ptr;
        cnt_n    = beat_cnt;
        if (state == IDLE && found) begin
            state_n = GRANT;
            grant_n = N'(1) << pick;
            ptr_n   = PW'((pick + 1) % N);
            cnt_n   = '0;
        end else if (gv && (!s_tvalid[g] || (hs && beat_cnt == CW'(BURST - 1)))) begin
            state_n = IDLE;
            grant_n = '0;
            cnt_n   = '0;
        end else if (hs) begin
            cnt_n = beat_cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: directed vector table plus hand-written multi-cycle sequences for axis_rr_arbiter
module tb_axis_rr_arbiter;
    logic        aclk = 1'b0;
    logic        aresetn;
    logic [3:0]  s_tvalid;
    logic [3:0]  s_tready;
    logic [31:0] s_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [7:0]  m_tdata;
    logic [3:0]  grant;
    logic [2:0]  beat_cnt;
    int          tests = 0;
    int          fails = 0;

    axis_rr_arbiter #(.N(4), .DATA_WIDTH(8), .BURST(4)) dut (
        .aclk(aclk), .aresetn(aresetn), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tdata(s_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .grant(grant), .beat_cnt(beat_cnt)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic        rstn;
        logic [3:0]  vld;
        logic [31:0] data;
        logic        rdy;
        logic [3:0]  e_grant;
        logic [2:0]  e_cnt;
        logic        e_mv;
        logic [7:0]  e_md;
        logic [3:0]  e_str;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic rstn, logic [3:0] vld, logic [31:0] data, logic rdy,
                                logic [3:0] eg, logic [2:0] ec, logic emv, logic [7:0] emd, logic [3:0] es);
        vec_t v;
        v = '{rstn, vld, data, rdy, eg, ec, emv, emd, es};
        return v;
    endfunction

    function automatic logic [31:0] d1(logic [7:0] b);
        return {16'h0, b, 8'h0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [3:0] eg, input logic [2:0] ec,
                           input logic emv, input logic [7:0] emd, input logic [3:0] es);
        @(negedge aclk);
        chk({nm, ".grant"}, 32'(grant), 32'(eg));
        chk({nm, ".beat_cnt"}, 32'(beat_cnt), 32'(ec));
        chk({nm, ".m_tvalid"}, 32'(m_tvalid), 32'(emv));
        chk({nm, ".m_tdata"}, 32'(m_tdata), 32'(emd));
        chk({nm, ".s_tready"}, 32'(s_tready), 32'(es));
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        aresetn  = 1'b0;
        s_tvalid = '0;
        s_tdata  = '0;
        m_tready = 1'b1;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    logic [3:0] fc [4];

    initial begin
        do_reset();
        for (int i = 0; i < 3; i++)
            tv.push_back(mk(0, 4'hF, 32'h44332211, 1, 0, 0, 0, 8'h00, 0));
        tv.push_back(mk(1, 4'hF, 32'h44332211, 1, 0, 0, 0, 8'h00, 0));
        tv.push_back(mk(1, 4'hF, 32'h44332211, 1, 4'b0001, 0, 1, 8'h11, 4'b0001));
        tv.push_back(mk(0, 4'h0, 32'h0, 1, 4'b0001, 1, 0, 8'h00, 4'b0001));
        tv.push_back(mk(1, 4'h0, 32'h0, 1, 0, 0, 0, 8'h00, 0));
        for (int grp = 0; grp < 2; grp++) begin
            tv.push_back(mk(1, 4'b0010, d1(8'(grp * 4)), 1, 0, 0, 0, 8'h00, 0));
            for (int b = 0; b < 4; b++)
                tv.push_back(mk(1, 4'b0010, d1(8'(grp * 4 + b)), 1, 4'b0010, 3'(b), 1, 8'(grp * 4 + b), 4'b0010));
        end
        tv.push_back(mk(1, 4'b0010, d1(8'h08), 1, 0, 0, 0, 8'h00, 0));
        tv.push_back(mk(1, 4'b0010, d1(8'h08), 1, 4'b0010, 0, 1, 8'h08, 4'b0010));
        tv.push_back(mk(1, 4'b0010, d1(8'h09), 1, 4'b0010, 1, 1, 8'h09, 4'b0010));
        tv.push_back(mk(1, 4'b0000, 32'h0, 1, 4'b0010, 2, 0, 8'h00, 4'b0010));
        tv.push_back(mk(1, 4'b0000, 32'h0, 1, 0, 0, 0, 8'h00, 0));
        foreach (tv[i]) begin
            aresetn  = tv[i].rstn;
            s_tvalid = tv[i].vld;
            s_tdata  = tv[i].data;
            m_tready = tv[i].rdy;
            chk_all($sformatf("vec%0d", i), tv[i].e_grant, tv[i].e_cnt, tv[i].e_mv, tv[i].e_md, tv[i].e_str);
        end

        // fairness: all four sources valid, each tags its bytes with its index
        do_reset();
        for (int i = 0; i < 4; i++) fc[i] = '0;
        s_tvalid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 4; i++) s_tdata[i*8 +: 8] = {4'(i), fc[i]};
            chk_all($sformatf("fair_idle%0d", k), 0, 0, 0, 8'h00, 0);
            for (int b = 0; b < 4; b++) begin
                for (int i = 0; i < 4; i++) s_tdata[i*8 +: 8] = {4'(i), fc[i]};
                chk_all($sformatf("fair%0d_b%0d", k, b), 4'(1 << (k % 4)), 3'(b), 1,
                        {4'(k % 4), fc[k % 4]}, 4'(1 << (k % 4)));
                fc[k % 4] = fc[k % 4] + 4'd1;
            end
        end

        // backpressure on requester 2 after two beats
        do_reset();
        s_tvalid = 4'b0100;
        s_tdata  = {8'h0, 8'h20, 16'h0};
        chk_all("bp_idle", 0, 0, 0, 8'h00, 0);
        for (int b = 0; b < 2; b++) begin
            s_tdata[23:16] = 8'(8'h20 + b);
            chk_all($sformatf("bp_b%0d", b), 4'b0100, 3'(b), 1, 8'(8'h20 + b), 4'b0100);
        end
        s_tdata[23:16] = 8'h22;
        m_tready = 1'b0;
        for (int w = 0; w < 5; w++)
            chk_all($sformatf("bp_hold%0d", w), 4'b0100, 2, 1, 8'h22, 4'b0000);
        m_tready = 1'b1;
        chk_all("bp_b2", 4'b0100, 2, 1, 8'h22, 4'b0100);
        s_tdata[23:16] = 8'h23;
        chk_all("bp_b3", 4'b0100, 3, 1, 8'h23, 4'b0100);
        s_tvalid = 4'b0000;
        chk_all("bp_release", 0, 0, 0, 8'h00, 0);

        // early release of requester 0 while requester 3 waits
        do_reset();
        s_tvalid = 4'b1001;
        s_tdata  = 32'hD00000A0;
        chk_all("er_idle", 0, 0, 0, 8'h00, 0);
        chk_all("er_b0", 4'b0001, 0, 1, 8'hA0, 4'b0001);
        s_tdata[7:0] = 8'hA1;
        chk_all("er_b1", 4'b0001, 1, 1, 8'hA1, 4'b0001);
        s_tvalid = 4'b1000;
        chk_all("er_drop", 4'b0001, 2, 0, 8'hA1, 4'b0001);
        chk_all("er_bubble", 0, 0, 0, 8'h00, 0);
        chk_all("er_g3", 4'b1000, 0, 1, 8'hD0, 4'b1000);

        // reset lands on a handshake with beat_cnt==2; ptr must return to 0
        do_reset();
        s_tvalid = 4'b0010;
        s_tdata  = d1(8'h50);
        chk_all("rm_idle", 0, 0, 0, 8'h00, 0);
        chk_all("rm_b0", 4'b0010, 0, 1, 8'h50, 4'b0010);
        chk_all("rm_b1", 4'b0010, 1, 1, 8'h50, 4'b0010);
        aresetn = 1'b0;
        chk_all("rm_b2", 4'b0010, 2, 1, 8'h50, 4'b0010);
        aresetn  = 1'b1;
        s_tvalid = 4'hF;
        s_tdata  = 32'h33221100;
        chk_all("rm_after", 0, 0, 0, 8'h00, 0);
        chk_all("rm_ptr0", 4'b0001, 0, 1, 8'h00, 4'b0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
